// File: rtl/store_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// store_monitor: checks observed memory stores, in order, against a table of
// expected {address, data} pairs, with scratch-address filtering and a timeout.
// Revision: 1.0
// ---------------------------------------------------------------------------
module store_monitor #(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 4,
   parameter int TIMEOUT     = 1024,
   parameter int IGNORE_EN   = 1,
   parameter int IGNORE_ADDR = 96
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [$clog2(DEPTH+1)-1:0]   cfg_len,
   input  logic                         cfg_we,
   input  logic [$clog2(DEPTH)-1:0]     cfg_idx,
   input  logic [WIDTH-1:0]             cfg_adr,
   input  logic [WIDTH-1:0]             cfg_data,
   input  logic                         mem_write,
   input  logic [WIDTH-1:0]             adr,
   input  logic [WIDTH-1:0]             write_data,
   output logic                         done,
   output logic                         pass,
   output logic [1:0]                   fail_code,
   output logic [$clog2(DEPTH+1)-1:0]   match_cnt,
   output logic [$clog2(TIMEOUT)-1:0]   cycle_cnt,
   output logic [WIDTH-1:0]             err_adr,
   output logic [WIDTH-1:0]             err_data
);

   localparam int LW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [CW-1:0] CMAX    = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      PASS  = 3'd2,
      FAIL  = 3'd3,
      TOUT  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  tbl_adr_q [DEPTH];
   logic [WIDTH-1:0]  tbl_adr_d [DEPTH];
   logic [WIDTH-1:0]  tbl_dat_q [DEPTH];
   logic [WIDTH-1:0]  tbl_dat_d [DEPTH];
   logic [LW-1:0]     len_q, len_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [LW-1:0]     match_q, match_d;
   logic [CW-1:0]     cycle_q, cycle_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [1:0]        fail_q, fail_d;
   logic [WIDTH-1:0]  err_adr_q, err_adr_d;
   logic [WIDTH-1:0]  err_dat_q, err_dat_d;

   logic w_ignore, w_hit, w_last, w_len_ok;

   assign w_ignore = (IGNORE_EN != 0) && (adr == WIDTH'(IGNORE_ADDR));
   assign w_hit    = (adr == tbl_adr_q[idx_q]) && (write_data == tbl_dat_q[idx_q]);
   assign w_last   = (LW'(idx_q) == (len_q - LW'(1)));
   assign w_len_ok = (cfg_len != '0) && (cfg_len <= DEPTH_L);

   always_comb begin
      state_d   = state_q;
      tbl_adr_d = tbl_adr_q;
      tbl_dat_d = tbl_dat_q;
      len_d     = len_q;
      idx_d     = idx_q;
      match_d   = match_q;
      cycle_d   = cycle_q;
      done_d    = done_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      err_adr_d = err_adr_q;
      err_dat_d = err_dat_q;

      if (state_q == ARMED) begin
         // Saturate so a timeout leaves cycle_cnt at TIMEOUT-1.
         if (cycle_q != CMAX) cycle_d = cycle_q + CW'(1);
         if (mem_write && !w_ignore) begin
            if (w_hit) begin
               match_d = match_q + LW'(1);
               idx_d   = idx_q + IW'(1);
               if (w_last) begin
                  state_d = PASS;
                  done_d  = 1'b1;
                  pass_d  = 1'b1;
               end
            end else begin
               state_d   = FAIL;
               done_d    = 1'b1;
               fail_d    = 2'd1;
               err_adr_d = adr;
               err_dat_d = write_data;
            end
         end
         if ((state_d == ARMED) && (cycle_q == CMAX)) begin
            state_d = TOUT;
            done_d  = 1'b1;
            fail_d  = 2'd2;
         end
      end else begin
         if (cfg_we) begin
            tbl_adr_d[cfg_idx] = cfg_adr;
            tbl_dat_d[cfg_idx] = cfg_data;
         end
         if (start) begin
            idx_d     = '0;
            match_d   = '0;
            cycle_d   = '0;
            err_adr_d = '0;
            err_dat_d = '0;
            pass_d    = 1'b0;
            if (w_len_ok) begin
               state_d = ARMED;
               len_d   = cfg_len;
               done_d  = 1'b0;
               fail_d  = 2'd0;
            end else begin
               state_d = FAIL;
               done_d  = 1'b1;
               fail_d  = 2'd3;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         tbl_adr_q <= '{default: '0};
         tbl_dat_q <= '{default: '0};
         len_q     <= '0;
         idx_q     <= '0;
         match_q   <= '0;
         cycle_q   <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 2'd0;
         err_adr_q <= '0;
         err_dat_q <= '0;
      end else begin
         state_q   <= state_d;
         tbl_adr_q <= tbl_adr_d;
         tbl_dat_q <= tbl_dat_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         match_q   <= match_d;
         cycle_q   <= cycle_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         err_adr_q <= err_adr_d;
         err_dat_q <= err_dat_d;
      end
   end

   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_code = fail_q;
   assign match_cnt = match_q;
   assign cycle_cnt = cycle_q;
   assign err_adr   = err_adr_q;
   assign err_data  = err_dat_q;

endmodule
`default_nettype wire

// File: tb/tb_store_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_store_monitor: directed scenario tests for store_monitor.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_store_monitor;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  cfg_len = '0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_idx = '0;
   logic [31:0] cfg_adr = '0;
   logic [31:0] cfg_data = '0;
   logic        mem_write = 1'b0;
   logic [31:0] adr = '0;
   logic [31:0] write_data = '0;
   logic        done;
   logic        pass;
   logic [1:0]  fail_code;
   logic [2:0]  match_cnt;
   logic [5:0]  cycle_cnt;
   logic [31:0] err_adr;
   logic [31:0] err_data;

   int total = 0;
   int bad   = 0;

   store_monitor #(
      .WIDTH(32), .DEPTH(4), .TIMEOUT(64), .IGNORE_EN(1), .IGNORE_ADDR(96)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr), .cfg_data(cfg_data),
      .mem_write(mem_write), .adr(adr), .write_data(write_data),
      .done(done), .pass(pass), .fail_code(fail_code), .match_cnt(match_cnt),
      .cycle_cnt(cycle_cnt), .err_adr(err_adr), .err_data(err_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] i, input logic [31:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_idx = i; cfg_adr = a; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic arm(input logic [2:0] len);
      cfg_len = len; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      mem_write = 1'b1; adr = a; write_data = d;
      tick();
      mem_write = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      total++; if (done !== 1'b0 || pass !== 1'b0 || fail_code !== 2'd0) begin bad++; $display("FAIL reset_flags got done=%0d pass=%0d fc=%0d exp 0 0 0", done, pass, fail_code); end
      total++; if (match_cnt !== 3'd0 || cycle_cnt !== 6'd0 || err_adr !== 32'd0 || err_data !== 32'd0) begin bad++; $display("FAIL reset_counts got m=%0d c=%0d ea=%0d ed=%0d exp all 0", match_cnt, cycle_cnt, err_adr, err_data); end
      tick();
      reset = 1'b0;
      tick();
      total++; if (done !== 1'b0 || cycle_cnt !== 6'd0) begin bad++; $display("FAIL reset_idle got done=%0d c=%0d exp 0 0", done, cycle_cnt); end
   endtask

   task automatic test_scratch_match();
      cfg_write(2'd0, 32'd100, 32'd7);
      arm(3'd1);
      total++; if (done !== 1'b0 || cycle_cnt !== 6'd0) begin bad++; $display("FAIL arm_state got done=%0d c=%0d exp 0 0", done, cycle_cnt); end
      store(32'd96, 32'd3);
      total++; if (done !== 1'b0 || match_cnt !== 3'd0 || cycle_cnt !== 6'd1) begin bad++; $display("FAIL scratch_ignored got done=%0d m=%0d c=%0d exp 0 0 1", done, match_cnt, cycle_cnt); end
      store(32'd100, 32'd7);
      total++; if (done !== 1'b1 || pass !== 1'b1 || match_cnt !== 3'd1 || fail_code !== 2'd0) begin bad++; $display("FAIL scratch_match got done=%0d pass=%0d m=%0d fc=%0d exp 1 1 1 0", done, pass, match_cnt, fail_code); end
      store(32'd5, 32'd5);
      tick();
      total++; if (done !== 1'b1 || pass !== 1'b1 || cycle_cnt !== 6'd2 || match_cnt !== 3'd1) begin bad++; $display("FAIL pass_sticky got done=%0d pass=%0d c=%0d m=%0d exp 1 1 2 1", done, pass, cycle_cnt, match_cnt); end
   endtask

   task automatic test_mismatch();
      arm(3'd1);
      total++; if (done !== 1'b0 || pass !== 1'b0 || match_cnt !== 3'd0) begin bad++; $display("FAIL rearm_clear got done=%0d pass=%0d m=%0d exp 0 0 0", done, pass, match_cnt); end
      store(32'd100, 32'd8);
      total++; if (done !== 1'b1 || fail_code !== 2'd1 || pass !== 1'b0 || match_cnt !== 3'd0) begin bad++; $display("FAIL mismatch_flags got done=%0d fc=%0d pass=%0d m=%0d exp 1 1 0 0", done, fail_code, pass, match_cnt); end
      total++; if (err_adr !== 32'd100 || err_data !== 32'd8) begin bad++; $display("FAIL mismatch_err got ea=%0d ed=%0d exp 100 8", err_adr, err_data); end
   endtask

   task automatic test_in_order();
      cfg_write(2'd0, 32'd0, 32'd1);
      cfg_write(2'd1, 32'd4, 32'd2);
      arm(3'd2);
      store(32'd4, 32'd2);
      total++; if (fail_code !== 2'd1 || done !== 1'b1 || err_adr !== 32'd4 || err_data !== 32'd2) begin bad++; $display("FAIL out_of_order got fc=%0d done=%0d ea=%0d ed=%0d exp 1 1 4 2", fail_code, done, err_adr, err_data); end
   endtask

   task automatic test_priority();
      arm(3'd2);
      store(32'd0, 32'd1);
      total++; if (match_cnt !== 3'd1 || done !== 1'b0) begin bad++; $display("FAIL prio_first got m=%0d done=%0d exp 1 0", match_cnt, done); end
      repeat (62) tick();
      total++; if (cycle_cnt !== 6'd63 || done !== 1'b0) begin bad++; $display("FAIL prio_pre got c=%0d done=%0d exp 63 0", cycle_cnt, done); end
      store(32'd4, 32'd2);
      total++; if (pass !== 1'b1 || fail_code !== 2'd0 || done !== 1'b1 || match_cnt !== 3'd2) begin bad++; $display("FAIL prio_final got pass=%0d fc=%0d done=%0d m=%0d exp 1 0 1 2", pass, fail_code, done, match_cnt); end
   endtask

   task automatic test_timeout();
      int n;
      cfg_write(2'd0, 32'd100, 32'd7);
      arm(3'd1);
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      total++; if (n != 64) begin bad++; $display("FAIL tout_edges got %0d exp 64", n); end
      total++; if (fail_code !== 2'd2 || cycle_cnt !== 6'd63 || pass !== 1'b0) begin bad++; $display("FAIL tout_flags got fc=%0d c=%0d pass=%0d exp 2 63 0", fail_code, cycle_cnt, pass); end
      store(32'd100, 32'd7);
      tick();
      total++; if (fail_code !== 2'd2 || pass !== 1'b0 || match_cnt !== 3'd0 || cycle_cnt !== 6'd63) begin bad++; $display("FAIL tout_sticky got fc=%0d pass=%0d m=%0d c=%0d exp 2 0 0 63", fail_code, pass, match_cnt, cycle_cnt); end
   endtask

   task automatic test_cfg_locked();
      arm(3'd1);
      cfg_write(2'd0, 32'd200, 32'd9);
      store(32'd100, 32'd7);
      total++; if (pass !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL cfg_locked got pass=%0d done=%0d exp 1 1", pass, done); end
   endtask

   task automatic test_cfg_error();
      arm(3'd0);
      total++; if (fail_code !== 2'd3 || done !== 1'b1 || pass !== 1'b0) begin bad++; $display("FAIL cfg_len0 got fc=%0d done=%0d pass=%0d exp 3 1 0", fail_code, done, pass); end
      arm(3'd5);
      total++; if (fail_code !== 2'd3 || done !== 1'b1) begin bad++; $display("FAIL cfg_len5 got fc=%0d done=%0d exp 3 1", fail_code, done); end
   endtask

   task automatic test_reset_midrun();
      cfg_write(2'd0, 32'd100, 32'd7);
      cfg_write(2'd1, 32'd104, 32'd8);
      arm(3'd2);
      store(32'd100, 32'd7);
      tick();
      total++; if (match_cnt !== 3'd1 || cycle_cnt !== 6'd2) begin bad++; $display("FAIL midrun_pre got m=%0d c=%0d exp 1 2", match_cnt, cycle_cnt); end
      #2 reset = 1'b1;
      #1;
      total++; if (match_cnt !== 3'd0 || cycle_cnt !== 6'd0 || done !== 1'b0 || pass !== 1'b0 || fail_code !== 2'd0) begin bad++; $display("FAIL async_reset got m=%0d c=%0d done=%0d pass=%0d fc=%0d exp all 0", match_cnt, cycle_cnt, done, pass, fail_code); end
      tick();
      reset = 1'b0;
      store(32'd104, 32'd8);
      repeat (3) tick();
      total++; if (done !== 1'b0 || cycle_cnt !== 6'd0 || match_cnt !== 3'd0) begin bad++; $display("FAIL post_reset_idle got done=%0d c=%0d m=%0d exp 0 0 0", done, cycle_cnt, match_cnt); end
      arm(3'd1);
      store(32'd0, 32'd0);
      total++; if (pass !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL table_cleared got pass=%0d done=%0d exp 1 1", pass, done); end
   endtask

   initial begin
      test_reset();
      test_scratch_match();
      test_mismatch();
      test_in_order();
      test_priority();
      test_timeout();
      test_cfg_locked();
      test_cfg_error();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/store_monitor.md
STORE_MONITOR -- requirements
Module: store_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter DEPTH, default 4, number of expected-store table entries (power of two, >=2).
REQ-003 SHALL have parameter TIMEOUT, default 1024, armed cycles allowed before timeout (>=2).
REQ-004 SHALL have parameters IGNORE_EN, default 1, and IGNORE_ADDR, default 96, which control scratch-store filtering.
REQ-005 SHALL have clk  input  1  rising-edge clock.
REQ-006 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have start  input  1  arms a run.
REQ-008 SHALL have cfg_len  input  $clog2(DEPTH+1)  expected-store count, sampled on start.
REQ-009 SHALL have cfg_we, cfg_idx, cfg_adr and cfg_data, which are inputs of widths 1, $clog2(DEPTH), WIDTH and WIDTH, and which write table entry cfg_idx.
REQ-010 SHALL have mem_write, adr and write_data, which are inputs of widths 1, WIDTH and WIDTH and come from the observed memory port.
REQ-011 SHALL have done, pass and fail_code, which are outputs of widths 1, 1 and 2 (0 none, 1 mismatch, 2 timeout, 3 config error).
REQ-012 SHALL have match_cnt, an output of width $clog2(DEPTH+1), and cycle_cnt, an output of width $clog2(TIMEOUT), which give progress.
REQ-013 SHALL have err_adr and err_data, both outputs of width WIDTH, which give the first offending store.

Function
REQ-014 SHALL implement the states IDLE, ARMED, PASS, FAIL and TOUT, all of them registered, with every output being registered.
REQ-015 SHALL write the table on the rising edge when cfg_we=1, but only in the states IDLE, PASS, FAIL and TOUT, and SHALL ignore cfg_we while ARMED.
REQ-016 SHALL respond to start=1 outside ARMED as follows: if cfg_len is in 1..DEPTH, it latches cfg_len, clears idx, match_cnt, cycle_cnt, err_adr, err_data, done, pass and fail_code, and enters ARMED; otherwise it enters FAIL with fail_code=3 and done=1.
REQ-017 SHALL ignore start while ARMED.
REQ-018 SHALL, while ARMED, increment cycle_cnt on every edge.
REQ-019 SHALL, while ARMED with mem_write=1, IGNORE_EN=1 and adr==IGNORE_ADDR, take no action other than the cycle_cnt increment.
REQ-020 SHALL, while ARMED with a non-ignored mem_write=1 where adr and write_data equal table[idx], increment match_cnt and idx.
REQ-021 SHALL enter PASS with done=1 and pass=1 on that same edge when the match is the last entry (idx==len-1).
REQ-022 SHALL, on a non-ignored mem_write=1 that mismatches, enter FAIL with fail_code=1 and done=1, capture adr into err_adr and write_data into err_data, and leave match_cnt unchanged.
REQ-023 SHALL check stores strictly in order; a store matching a later entry counts as a mismatch.
REQ-024 SHALL, when ARMED with cycle_cnt==TIMEOUT-1 and no completing match on that edge, enter TOUT with fail_code=2 and done=1.
REQ-025 SHALL give a final match priority over timeout on the same edge, so the result is PASS.
REQ-026 SHALL hold PASS, FAIL and TOUT, together with all outputs, sticky until the next start or reset.
REQ-027 SHALL ignore mem_write outside ARMED.
REQ-028 SHALL freeze cycle_cnt outside ARMED.
REQ-029 SHALL have no combinational path from any input to any output.

Reset
REQ-030 SHALL, on reset=1, immediately force the state to IDLE regardless of clk.
REQ-031 SHALL, on reset=1, clear done, pass, fail_code, match_cnt, cycle_cnt, err_adr, err_data, the latched length, idx and all table entries to 0.
REQ-032 SHALL, when reset asserts mid-run, abandon the run with no result reported.
REQ-033 SHALL treat the first edge after reset deasserts as an ordinary IDLE edge.

Verification (WIDTH=32, DEPTH=4, TIMEOUT=64, IGNORE_ADDR=96)
REQ-034 SHALL cover scratch-then-match: with table[0]={100,7}, len=1, start, then a store to 96 with data 3, then a store to 100 with data 7 -> after the second store's edge done=1, pass=1, match_cnt=1 and fail_code=0.
REQ-035 SHALL cover mismatch: with the same table, start, then a store to 100 with data 8 -> fail_code=1, err_adr=100, err_data=8, pass=0 and match_cnt=0.
REQ-036 SHALL cover timeout: with the same table, start and no stores -> done rises on the 64th armed edge with fail_code=2 and cycle_cnt=63 held; any later store has no effect.
REQ-037 SHALL cover priority: with len=2 and table {{0,1},{4,2}}, a store to 0 with data 1, then a store to 4 with data 2 exactly on the cycle_cnt==63 edge -> pass=1 and fail_code=0.
REQ-038 SHALL cover config error and reset: start with cfg_len=0 -> fail_code=3 and done=1; then re-arm with a valid config, assert reset mid-run -> all outputs are 0 at once, the table is cleared, and the state is IDLE.
